counter_sequencer: RTL and testbench

Run-control FSM for the lab's 8-bit T-flip-flop enable counter. It drives the counter's Enable and synchronous clear, watches the returned CounterValue, and turns the free-running counter into a programmable interval timer. Supported modes are one-shot and periodic, with pause and abort. It sits between the user controls (KEY/SW) and the counter instance, and emits a one-cycle Tick per elapsed period plus a saturating tick tally.

---
 rtl/counter_sequencer.sv | 96 +++++++++
 tb/tb_counter_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run-control FSM for an external enable counter: turns the free-running counter
// into a one-shot or periodic interval timer with pause, abort and a tick tally.
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Period,
  input  logic [WIDTH-1:0] CntValue,
  output logic             CntEnable,
  output logic             CntClear,
  output logic             Tick,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       State,
  output logic [7:0]       TickCount
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] period_reg;
  logic             mode_reg;
  logic             terminal;
  logic             accept;

  // Terminal is the last enabled cycle of a period; the counter clears instead of incrementing.
  always_comb begin
    terminal = (state == RUN) && !Pause && !Stop &&
               (CntValue == (period_reg - WIDTH'(1)));
    accept   = ((state == IDLE) || (state == DONE)) && !Stop && Start &&
               (Period != '0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (Stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (accept) state_next = RUN;
        RUN: begin
          if (Pause)                     state_next = HOLD;
          else if (terminal && !mode_reg) state_next = DONE;
        end
        HOLD: if (!Pause) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    CntEnable = (state == RUN);
    CntClear  = (state == IDLE) || (state == DONE) || terminal;
    Busy      = (state == RUN) || (state == HOLD);
    Done      = (state == DONE);
    State     = state;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      period_reg <= '0;
      mode_reg   <= 1'b0;
      Tick       <= 1'b0;
      TickCount  <= '0;
    end else begin
      Tick <= terminal;
      if (accept) begin
        period_reg <= Period;
        mode_reg   <= Mode;
        TickCount  <= '0;
      end else if (terminal && (TickCount != '1)) begin
        TickCount <= TickCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a behavioural lab counter plus a
// cycle model of the timer rules; a negedge monitor compares every cycle.
module tb_counter_sequencer;

  localparam int W = 8;

  logic         Clock    = 1'b0;
  logic         Resetn   = 1'b1;
  logic         Start    = 1'b0;
  logic         Stop     = 1'b0;
  logic         Pause    = 1'b0;
  logic         Mode     = 1'b0;
  logic [W-1:0] Period   = '0;
  logic [W-1:0] CntValue = '0;
  logic         CntEnable, CntClear, Tick, Busy, Done;
  logic [1:0]   State;
  logic [7:0]   TickCount;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  counter_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .Pause(Pause),
    .Mode(Mode), .Period(Period), .CntValue(CntValue), .CntEnable(CntEnable),
    .CntClear(CntClear), .Tick(Tick), .Busy(Busy), .Done(Done), .State(State),
    .TickCount(TickCount)
  );

  always #5 Clock = ~Clock;

  // The lab counter: synchronous clear beats enable, no reset of its own.
  always @(posedge Clock) begin
    if (CntClear)       CntValue <= '0;
    else if (CntEnable) CntValue <= CntValue + 8'd1;
  end

  // Reference model: 0=idle 1=run 2=hold 3=done; m_cnt is the expected counter value.
  int m_state = 0;
  int m_per   = 0;
  bit m_mode  = 0;
  int m_tc    = 0;
  bit m_tick  = 0;
  int m_cnt   = 0;
  int exp_q[$];

  // Resetn only changes while Clock is low, so Clock==1 marks a clock edge.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_state = 0; m_per = 0; m_mode = 0; m_tc = 0; m_tick = 0;
      exp_q.delete();
      if (Clock) m_cnt = 0;
    end else begin
      int  old;
      bit  term;
      old  = m_state;
      term = (old == 1) && !Pause && !Stop && (m_cnt == ((m_per - 1) & 255));
      if (old == 0 || old == 3 || term) m_cnt = 0;
      else if (old == 1)                m_cnt = (m_cnt + 1) % 256;
      m_tick = term;
      if (term) begin
        if (m_tc < 255) m_tc++;
        exp_q.push_back(m_tc);
      end
      if (Stop) m_state = 0;
      else begin
        case (old)
          0, 3: if (Start && Period != 0) begin
            m_state = 1; m_per = int'(Period); m_mode = Mode; m_tc = 0;
          end
          1: if (Pause) m_state = 2;
             else if (term && !m_mode) m_state = 3;
          2: if (!Pause) m_state = 1;
          default: m_state = 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      bit term_now;
      term_now = (m_state == 1) && !Pause && !Stop && (m_cnt == ((m_per - 1) & 255));
      chk("state",     int'(State),     m_state);
      chk("tick",      int'(Tick),      int'(m_tick));
      chk("tickcount", int'(TickCount), m_tc);
      chk("cntvalue",  int'(CntValue),  m_cnt);
      chk("cntenable", int'(CntEnable), int'(m_state == 1));
      chk("cntclear",  int'(CntClear),  int'(m_state == 0 || m_state == 3 || term_now));
      chk("busy",      int'(Busy),      int'(m_state == 1 || m_state == 2));
      chk("done",      int'(Done),      int'(m_state == 3));
      if (Tick) begin
        if (exp_q.size() == 0) chk("tick_unexpected", 1, 0);
        else                   chk("tick_tally", int'(TickCount), exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic wait_cnt(input int v);
    int guard;
    guard = 0;
    while (int'(CntValue) != v && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) chk("wait_cnt_timeout", int'(CntValue), v);
  endtask

  task automatic start_run(input int p, input bit m);
    Start = 1'b1; Period = W'(p); Mode = m;
    step();
    Start = 1'b0;
  endtask

  task automatic abort();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    step();
  endtask

  task automatic reset_now_checks();
    chk("rst_state",     int'(State),     0);
    chk("rst_cntclear",  int'(CntClear),  1);
    chk("rst_cntenable", int'(CntEnable), 0);
    chk("rst_busy",      int'(Busy),      0);
    chk("rst_done",      int'(Done),      0);
    chk("rst_tick",      int'(Tick),      0);
    chk("rst_tickcount", int'(TickCount), 0);
  endtask

  initial begin
    #1 Resetn = 1'b0;
    #1 reset_now_checks();
    chk_en = 1'b1;
    #19 Resetn = 1'b1;
    step();

    // Periodic, period 5
    start_run(5, 1'b1);
    step(20);
    abort();

    // One-shot period 3, then a second run with period 2
    start_run(3, 1'b0);
    step(6);
    start_run(2, 1'b0);
    step(5);

    // Pause for 4 cycles at count 6 of a 10-cycle period
    start_run(10, 1'b1);
    wait_cnt(6);
    Pause = 1'b1;
    step(4);
    Pause = 1'b0;
    step(25);
    abort();

    // Period 0 is ignored; period 1 ticks every cycle and saturates the tally
    start_run(0, 1'b1);
    step(3);
    start_run(1, 1'b1);
    step(300);
    chk("saturated", int'(TickCount), 255);
    abort();

    // Stop on the terminal cycle, then Start together with Stop
    start_run(4, 1'b1);
    wait_cnt(3);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    step(3);
    Start = 1'b1; Stop = 1'b1; Period = 8'd5;
    step();
    Start = 1'b0; Stop = 1'b0;
    step(2);

    // Asynchronous reset mid-run at count 4
    start_run(8, 1'b1);
    wait_cnt(4);
    @(negedge Clock);
    #1 Resetn = 1'b0;
    #1 reset_now_checks();
    chk("rst_cnt_held", int'(CntValue), 4);
    step(2);
    @(negedge Clock);
    #1 Resetn = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      Start  = ($urandom_range(0, 7) == 0);
      Stop   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) Pause = ~Pause;
      Mode   = $urandom_range(0, 1) != 0;
      Period = W'($urandom_range(0, 12));
      step();
    end
    Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
    abort();
    step(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
